// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types, constants and helpers for APB completer models.
// Revision    : 1.0  initial release
// ============================================================================
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_t;

  localparam int APB_ADDR_W = 32;

  // Increment a counter of 'width' bits, holding it at all-ones once reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
    logic [31:0] top;
    top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (cnt == top) ? cnt : (cnt + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_wait_ctr
// Description : Loadable down-counter that stops at zero; used to insert
//               wait states in APB completers.
// Revision    : 1.0  initial release
// ============================================================================
module apb_slave_wait_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             pclk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down while enabled and not yet at zero.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : Word-addressed APB3 completer memory with programmable wait
//               states, out-of-range error response, sticky protocol-violation
//               flag and saturating read/write transfer counters.
// Revision    : 1.0  initial release
// ============================================================================
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int WAIT_W     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  pclk,
  input  logic                  resetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [WAIT_W-1:0]     wait_cycles,
  output logic                  proto_err,
  output logic [CNT_W-1:0]      wr_count,
  output logic [CNT_W-1:0]      rd_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_slv_state_t        state, next_state;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic setup, complete, abort, proto_viol, wait_zero, wait_en, in_range;

  assign in_range = (paddr < APB_ADDR_W'(DEPTH));
  assign wait_en  = (state == ACCESS) && psel && penable;

  apb_slave_wait_ctr #(.WIDTH(WAIT_W)) u_wait_ctr (
    .pclk     (pclk),
    .resetn   (resetn),
    .load     (setup),
    .load_val (wait_cycles),
    .en       (wait_en),
    .zero     (wait_zero)
  );

  // State register.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next state, bus response and transfer events; outputs decode registered state only.
  always_comb begin
    next_state = state;
    pready     = 1'b0;
    pslverr    = 1'b0;
    prdata     = '0;
    setup      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    proto_viol = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          setup      = 1'b1;
          next_state = ACCESS;
        end else if (psel && penable) begin
          proto_viol = 1'b1;
        end
      end
      ACCESS: begin
        pready  = wait_zero;
        pslverr = wait_zero && err_q;
        prdata  = wait_zero ? rdata_q : '0;
        if (!psel) begin
          abort      = 1'b1;
          proto_viol = 1'b1;
          next_state = IDLE;
        end else begin
          if (!penable) proto_viol = 1'b1;
          if ((paddr != paddr_q) || (pwrite != write_q) || (pwdata != wdata_q)) proto_viol = 1'b1;
          if (penable && wait_zero) begin
            complete   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the request in the setup cycle; count completed transfers; track violations.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      paddr_q   <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      proto_err <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      if (setup) begin
        paddr_q <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        err_q   <= !in_range;
        rdata_q <= (!pwrite && in_range) ? mem[paddr[AW-1:0]] : '0;
      end else if (complete || abort) begin
        rdata_q <= '0;
      end
      if (complete) begin
        if (write_q) wr_count <= CNT_W'(sat_inc(32'(wr_count), CNT_W));
        else         rd_count <= CNT_W'(sat_inc(32'(rd_count), CNT_W));
      end
      if (proto_viol) proto_err <= 1'b1;
    end
  end

  // Memory array; only an in-range write that completes is committed.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (complete && write_q && !err_q) begin
      mem[paddr_q[AW-1:0]] <= wdata_q;
    end
  end

endmodule
`default_nettype wire
